// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and FSM state type for the TDM demultiplexer.
package demux_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] LAST_SLOT = 2'd3;
    typedef enum logic {HUNT, LOCK} state_e;
endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: 2-bit slot index counter; clear wins over load-to-1, which wins over advance.
module demux_slot_ctr import demux_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             load1_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] cnt_o
);
    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : load1_i ? SEL_W'(1) : adv_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/demux_tdm.sv
// demux_tdm: 4-slot TDM demultiplexer with sync tracking and whole-frame publish.
// Optional frame counter output enabled by DEMUX_FRAME_CNT_EN.
module demux_tdm import demux_pkg::*; #(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           Y,
    input  logic                       sync,
    input  logic                       G,
    output logic [SEL_W-1:0]           C,
    output logic [NUM_SLOTS*WIDTH-1:0] X,
    output logic                       frame_valid,
    output logic                       sync_err,
    output logic                       locked
`ifdef DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]                 frame_cnt
`endif
);
    state_e                         state_q;
    logic [(NUM_SLOTS-1)*WIDTH-1:0] shadow_q;
    logic [NUM_SLOTS*WIDTH-1:0]     x_q;
    logic                           fv_q, err_q;
    logic                           valid, in_lock, load1, miss, early, adv, done;

    // In HUNT the counter is always 0, so a sync beat loads slot 0 in either state.
    assign valid   = !G;
    assign in_lock = state_q == LOCK;
    assign load1   = valid && sync;
    assign miss    = valid && in_lock && !sync && C == '0;
    assign early   = valid && in_lock && sync && C != '0;
    assign adv     = valid && in_lock && !sync && C != '0;
    assign done    = adv && C == LAST_SLOT;

    demux_slot_ctr u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .load1_i (load1),
        .clr_i   (miss),
        .cnt_o   (C)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            x_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fv_q  <= done;
            err_q <= miss || early;
            if (load1) begin
                state_q               <= LOCK;
                shadow_q[WIDTH-1:0]   <= Y;
            end else if (miss) begin
                state_q <= HUNT;
            end
            for (int k = 1; k < NUM_SLOTS - 1; k++)
                if (adv && C == SEL_W'(k)) shadow_q[k*WIDTH +: WIDTH] <= Y;
            if (done) x_q <= {Y, shadow_q};
        end

    assign X           = x_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = state_q == LOCK;

`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                         cnt_q <= '0;
        else if (miss || early)             cnt_q <= '0;
        else if (done && cnt_q != 8'hFF)    cnt_q <= cnt_q + 8'd1;

    assign frame_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux_tdm.sv
// tb_demux_tdm: frame-level reference model plus directed frames for demux_tdm.
module tb_demux_tdm;
    logic       clk = 1'b0;
    logic       rst_n, sync, G;
    logic [0:0] Y;
    logic [1:0] C;
    logic [3:0] X;
    logic       frame_valid, sync_err, locked;
`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif
    int tests = 0;
    int errors = 0;

    demux_tdm #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Y           (Y),
        .sync        (sync),
        .G           (G),
        .C           (C),
        .X           (X),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
`ifdef DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: a receiver that is either hunting or expects slot m_slot next,
    // collecting bits into m_part and publishing the whole frame at its end.
    bit         m_lk, m_fv, m_err;
    int         m_slot, m_cnt;
    logic [3:0] m_part, m_x;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_lk = 0; m_slot = 0; m_part = '0; m_x = '0; m_fv = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_fv = 0;
            m_err = 0;
            if (!G) begin
                if (sync) begin
                    if (m_lk && m_slot != 0) begin m_err = 1; m_cnt = 0; end
                    m_lk = 1;
                    m_part[0] = Y[0];
                    m_slot = 1;
                end else if (m_lk && m_slot == 0) begin
                    m_err = 1; m_cnt = 0; m_lk = 0;
                end else if (m_lk) begin
                    m_part[m_slot] = Y[0];
                    m_slot = (m_slot + 1) % 4;
                    if (m_slot == 0) begin
                        m_x = m_part; m_fv = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_C", 32'(C), 32'(m_slot));
        chk("cmp_X", 32'(X), 32'(m_x));
        chk("cmp_fv", 32'(frame_valid), 32'(m_fv));
        chk("cmp_err", 32'(sync_err), 32'(m_err));
        chk("cmp_locked", 32'(locked), 32'(m_lk));
`ifdef DEMUX_FRAME_CNT_EN
        chk("cmp_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
    end

    task automatic drive(input logic y, input logic s, input logic g);
        Y = y; sync = s; G = g;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [3:0] d);
        drive(d[0], 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(d[i], 1'b0, 1'b0);
        chk("frame_X", 32'(X), 32'(d));
        chk("frame_fv", 32'(frame_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; Y = 1'b0; sync = 1'b0; G = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_X", 32'(X), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;

        drive(1, 1, 0);
        chk("f1_locked", 32'(locked), 32'd1);
        chk("f1_C1", 32'(C), 32'd1);
        drive(0, 0, 0);
        chk("f1_C2", 32'(C), 32'd2);
        drive(1, 0, 0);
        chk("f1_fv_early", 32'(frame_valid), 32'd0);
        drive(1, 0, 0);
        chk("f1_X", 32'(X), 32'hD);
        chk("f1_fv", 32'(frame_valid), 32'd1);
        chk("f1_C0", 32'(C), 32'd0);
        drive(0, 0, 1);
        chk("f1_fv_once", 32'(frame_valid), 32'd0);
        chk("f1_X_hold", 32'(X), 32'hD);

        frame(4'b0110);

        drive(1, 1, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'(i), 1'b0, 1'b1);
            chk("stall_C", 32'(C), 32'd2);
            chk("stall_fv", 32'(frame_valid), 32'd0);
            chk("stall_X", 32'(X), 32'h6);
        end
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("stall_X_done", 32'(X), 32'hD);
        chk("stall_fv_done", 32'(frame_valid), 32'd1);

        drive(0, 1, 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        chk("early_err", 32'(sync_err), 32'd1);
        chk("early_X", 32'(X), 32'hD);
        chk("early_C", 32'(C), 32'd1);
        chk("early_locked", 32'(locked), 32'd1);
        drive(0, 0, 0);
        chk("early_err_once", 32'(sync_err), 32'd0);
        drive(0, 0, 0);
        drive(1, 0, 0);
        chk("early_X_new", 32'(X), 32'h9);
        chk("early_fv", 32'(frame_valid), 32'd1);

        drive(1, 0, 0);
        chk("miss_err", 32'(sync_err), 32'd1);
        chk("miss_locked", 32'(locked), 32'd0);
        chk("miss_C", 32'(C), 32'd0);
        chk("miss_X", 32'(X), 32'h9);
        drive(1, 0, 0);
        chk("hunt_C", 32'(C), 32'd0);
        chk("hunt_err", 32'(sync_err), 32'd0);
        drive(0, 1, 0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_C", 32'(C), 32'd1);

        drive(1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_X", 32'(X), 32'd0);
        chk("arst_C", 32'(C), 32'd0);
        chk("arst_fv", 32'(frame_valid), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            chk("post_rst_fv", 32'(frame_valid), 32'd0);
        end
        frame(4'b1111);

        for (int f = 0; f < 8; f++) frame(4'($urandom_range(0, 15)));
`ifdef DEMUX_FRAME_CNT_EN
        for (int f = 0; f < 300; f++) frame(4'($urandom_range(0, 15)));
        chk("cnt_sat", 32'(frame_cnt), 32'd255);
        drive(1, 1, 0);
        drive(0, 1, 0);
        chk("cnt_clr", 32'(frame_cnt), 32'd0);
        chk("cnt_clr_err", 32'(sync_err), 32'd1);
`endif
        drive(0, 0, 1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/demux_tdm.md
Name: demux_tdm

Overview:
- 4-slot time-division demultiplexer; the receive-side counterpart of the 4:1 selector (select C, data X, active-low gate G, output Y).
- Takes the serial slot stream Y plus a slot-0 sync marker, tracks the slot index, and routes each slot into a per-channel shadow register.
- Publishes a complete 4-channel frame on X with a one-cycle frame_valid pulse.
- Sits on the link receive path, downstream of the TDM mux.

Parameters:
- WIDTH, 1, bits per slot (data width of Y and of each channel in X)
- NUM_SLOTS, 4, slots per frame; fixed at 4 in this revision (SEL_W = 2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Y  input  WIDTH  serial slot data
- sync  input  1  high during the slot-0 beat of each frame
- G  input  1  active-low gate: 0 = beat valid, 1 = stall (no capture, no advance)
- C  output  2  slot index expected on the next valid beat
- X  output  4*WIDTH  last complete frame; channel k at X[k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse when X updates
- sync_err  output  1  one-cycle pulse on a sync protocol violation
- locked  output  1  high while in LOCK

Behaviour:
- Reset (async assert, sync release): state=HUNT, C=0, X=0, shadow=0, frame_valid=0, sync_err=0, locked=0.
- A valid beat is a rising edge with G=0. With G=1: no capture, C holds, sync is ignored, and frame_valid/sync_err are 0 next cycle.
- HUNT state:
  - Valid beat with sync=1: shadow[0]<=Y, C<=1, go to LOCK.
  - Valid beat with sync=0: discard the beat, stay in HUNT, C stays 0.
- LOCK state, valid beat with C=k:
  - k=0 and sync=1: shadow[0]<=Y, C<=1.
  - k=0 and sync=0: missed sync. sync_err pulses, go to HUNT, C<=0, no capture, X unchanged.
  - k in 1..2 and sync=0: shadow[k]<=Y, C<=k+1.
  - k=3 and sync=0: X<={Y, shadow[2], shadow[1], shadow[0]}, C<=0 (wrap), frame_valid=1 for the next cycle only.
  - k in 1..3 and sync=1: early sync. sync_err pulses, the partial frame is dropped (X unchanged, no frame_valid), the beat is taken as slot 0 (shadow[0]<=Y, C<=1), and the block stays in LOCK.
- Latency: X and frame_valid are registered and change on the same edge as the slot-3 capture, one cycle after Y of slot 3 is presented.
- Back-to-back frames with G held 0 give a frame_valid pulse every 4 cycles.
- X holds its value between frames and is never partially updated.
- locked = (state==LOCK), registered.
- Reset asserted mid-frame: partial frame lost, all outputs return to reset values immediately.

Optional Feature:
- Macro: DEMUX_FRAME_CNT_EN.
- Defined:
  - Extra output frame_cnt, 8 bits, reset 0.
  - Increments on every frame_valid, saturates at 255.
  - Cleared on any sync_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - NUM_SLOTS=4 and SEL_W=2
  - state enum {HUNT, LOCK}
  - helper constant LAST_SLOT=3
- One sub-module, demux_slot_ctr: 2-bit slot counter with advance, load-to-1, and clear-to-0 controls.
- Routing, shadow registers, FSM and error logic stay in demux_tdm.

Test Plan:
- Reset, then sync=1 with Y=1,0,1,1 over 4 beats (G=0), WIDTH=1 -> X=4'b1101 and frame_valid high for exactly 1 cycle, one cycle after the 4th beat; locked=1 from the cycle after beat 1.
- Same frame with G=1 for 3 cycles inserted between slots 1 and 2 -> C holds at 2 during the stall; X=4'b1101 after the 4th valid beat; no extra pulses.
- In LOCK, sync=1 on slot 2 -> sync_err pulses once; X keeps the previous frame; C=1 next cycle; following 3 beats Y=0,0,1 complete the frame -> X={1,0,0,Yresync}.
- In LOCK, slot-0 beat with sync=0 -> sync_err pulse, locked=0, C=0; next valid sync beat relocks.
- rst_n pulled low asynchronously between clock edges mid-frame -> X=0, C=0, frame_valid=0 before the next clk edge; no frame_valid after release until a full new frame arrives.
- With DEMUX_FRAME_CNT_EN: 300 continuous frames -> frame_cnt=255; one early sync -> frame_cnt=0.
